// File: rtl/vga_timing_pkg.sv
// -----------------------------------------------------------------------------
// vga_timing_pkg
// Shared 640x480@60 Hz timing constants for the scan controller, the letter
// generator and the bench. Holds the default porch/pulse widths, the derived
// line/frame totals and sync windows, the counter width, and a small window
// test used by the sync decoders.
// -----------------------------------------------------------------------------
package vga_timing_pkg;

  localparam int CNT_W = 10;

  localparam int DEF_HD  = 640;
  localparam int DEF_HF  = 16;
  localparam int DEF_HR  = 96;
  localparam int DEF_HB  = 48;
  localparam int DEF_VD  = 480;
  localparam int DEF_VF  = 10;
  localparam int DEF_VR  = 2;
  localparam int DEF_VB  = 33;
  localparam int DEF_DIV = 4;

  localparam int DEF_HT       = DEF_HD + DEF_HF + DEF_HR + DEF_HB;  // 800
  localparam int DEF_VT       = DEF_VD + DEF_VF + DEF_VR + DEF_VB;  // 525
  localparam int DEF_HS_START = DEF_HD + DEF_HF;                     // 656
  localparam int DEF_HS_END   = DEF_HD + DEF_HF + DEF_HR - 1;        // 751
  localparam int DEF_VS_START = DEF_VD + DEF_VF;                     // 490
  localparam int DEF_VS_END   = DEF_VD + DEF_VF + DEF_VR - 1;        // 491

  typedef logic [CNT_W-1:0] cnt_t;

  // True when value lies in the inclusive window lo..hi.
  function automatic logic in_window(cnt_t value, int lo, int hi);
    return (int'(value) >= lo) && (int'(value) <= hi);
  endfunction

endpackage

// File: rtl/vga_sync_controller_if.sv
// -----------------------------------------------------------------------------
// vga_sync_controller_if
// Bundles the scan controller's video-side signals.
//   rgbswitches : raw colour switches into the controller
//   hsync/vsync : active-low syncs, registered
//   videoon     : visible-area flag
//   pixelx/y    : scan counters
//   ptick       : one-clk pixel enable
//   framestart  : one-clk pulse when the scan wraps to (0,0)
//   rgbsel      : frame-stable colour selection
// There is no handshake: every output is valid on every clk and consumers
// qualify pixel-rate work with ptick.
// master = the controller, slave = the letter generator / connector side.
// -----------------------------------------------------------------------------
interface vga_sync_controller_if;

  logic                     [2:0] rgbswitches;
  logic                           hsync;
  logic                           vsync;
  logic                           videoon;
  vga_timing_pkg::cnt_t           pixelx;
  vga_timing_pkg::cnt_t           pixely;
  logic                           ptick;
  logic                           framestart;
  logic                     [2:0] rgbsel;

  modport master (
    input  rgbswitches,
    output hsync, vsync, videoon, pixelx, pixely, ptick, framestart, rgbsel
  );

  modport slave (
    output rgbswitches,
    input  hsync, vsync, videoon, pixelx, pixely, ptick, framestart, rgbsel
  );

endinterface

// File: rtl/pixel_tick_gen.sv
// -----------------------------------------------------------------------------
// pixel_tick_gen
// Free-running clock divider producing a one-clk pixel enable.
//   clk    : system clock
//   resetn : asynchronous active-low reset
//   ptick  : high for one clk whenever the divider sits at DIV-1
// DIV must be a power of two >= 2 so the counter wraps naturally.
// -----------------------------------------------------------------------------
module pixel_tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic resetn,
  output logic ptick
);

  localparam int W = $clog2(DIV);

  logic [W-1:0] r_div;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + W'(1);
    end
  end

  assign ptick = (r_div == W'(DIV - 1));

endmodule

// File: rtl/vga_sync_controller.sv
// -----------------------------------------------------------------------------
// vga_sync_controller
// Scan timing sequencer for the 640x480@60 Hz text display path.
//   clk    : 100 MHz system clock
//   resetn : asynchronous active-low reset
//   bus    : video-side signals (see vga_sync_controller_if), master side
// Divides clk into the pixel enable, runs the horizontal/vertical scan
// counters, decodes registered syncs, and latches the synchronised colour
// switches once per frame so a colour change never tears mid-frame.
// -----------------------------------------------------------------------------
module vga_sync_controller
  import vga_timing_pkg::*;
#(
  parameter int HD  = DEF_HD,
  parameter int HF  = DEF_HF,
  parameter int HR  = DEF_HR,
  parameter int HB  = DEF_HB,
  parameter int VD  = DEF_VD,
  parameter int VF  = DEF_VF,
  parameter int VR  = DEF_VR,
  parameter int VB  = DEF_VB,
  parameter int DIV = DEF_DIV
) (
  input  logic                  clk,
  input  logic                  resetn,
  vga_sync_controller_if.master bus
);

  localparam int HT       = HD + HF + HR + HB;
  localparam int VT       = VD + VF + VR + VB;
  localparam int HS_START = HD + HF;
  localparam int HS_END   = HD + HF + HR - 1;
  localparam int VS_START = VD + VF;
  localparam int VS_END   = VD + VF + VR - 1;

  logic       w_ptick;
  logic       w_h_last;
  logic       w_v_last;
  logic       w_wrap;
  cnt_t       w_h_next;
  cnt_t       w_v_next;

  cnt_t       r_h;
  cnt_t       r_v;
  logic       r_hsync;
  logic       r_vsync;
  logic       r_framestart;
  logic [2:0] r_sync1;
  logic [2:0] r_sync2;
  logic [2:0] r_rgbsel;

  pixel_tick_gen #(
    .DIV (DIV)
  ) u_tick (
    .clk    (clk),
    .resetn (resetn),
    .ptick  (w_ptick)
  );

  // ">=" rather than "==" so an out-of-range count (e.g. after an upset)
  // is treated as the last position and wraps to 0 on the next advance.
  assign w_h_last = (r_h >= cnt_t'(HT - 1));
  assign w_v_last = (r_v >= cnt_t'(VT - 1));

  always_comb begin
    w_h_next = w_h_last ? '0 : r_h + cnt_t'(1);
    w_v_next = r_v;
    if (w_h_last) begin
      w_v_next = w_v_last ? '0 : r_v + cnt_t'(1);
    end
  end

  // The advance that takes the scan to (0,0).
  assign w_wrap = w_ptick && w_h_last && w_v_last;

  // Syncs are decoded from the next count and registered with the counters,
  // so they line up exactly with pixelx/pixely.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_h     <= '0;
      r_v     <= '0;
      r_hsync <= 1'b1;
      r_vsync <= 1'b1;
    end else if (w_ptick) begin
      r_h     <= w_h_next;
      r_v     <= w_v_next;
      r_hsync <= !in_window(w_h_next, HS_START, HS_END);
      r_vsync <= !in_window(w_v_next, VS_START, VS_END);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_framestart <= 1'b0;
    end else begin
      r_framestart <= w_wrap;
    end
  end

  // Two-flop synchroniser for the asynchronous switches, then a frame latch
  // that only loads on the wrap edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_rgbsel <= '0;
    end else begin
      r_sync1 <= bus.rgbswitches;
      r_sync2 <= r_sync1;
      if (w_wrap) begin
        r_rgbsel <= r_sync2;
      end
    end
  end

  assign bus.hsync      = r_hsync;
  assign bus.vsync      = r_vsync;
  assign bus.videoon    = (r_h < cnt_t'(HD)) && (r_v < cnt_t'(VD));
  assign bus.pixelx     = r_h;
  assign bus.pixely     = r_v;
  assign bus.ptick      = w_ptick;
  assign bus.framestart = r_framestart;
  assign bus.rgbsel     = r_rgbsel;

endmodule

// File: tb/tb_vga_sync_controller.sv
// -----------------------------------------------------------------------------
// tb_vga_sync_controller
// Three controllers share clk/resetn/switches:
//   id 0 : default 640x480 timing, DIV=4
//   id 1 : shrunken geometry (HT=32, VT=17), DIV=4
//   id 2 : shrunken geometry, DIV=2
// A model derives every output from the number of clk edges since reset
// release; one process compares all three DUTs against it each cycle.
// -----------------------------------------------------------------------------
module tb_vga_sync_controller;

  typedef struct packed {
    logic       hsync;
    logic       vsync;
    logic       videoon;
    logic [9:0] pixelx;
    logic [9:0] pixely;
    logic       ptick;
    logic       framestart;
    logic [2:0] rgbsel;
  } vid_t;

  logic       clk;
  logic       resetn;
  logic [2:0] sw;
  logic       chk_on;

  int         n_checks;
  int         n_errors;
  int         cyc;
  int         k;
  logic [2:0] sw_hist [0:65535];
  logic [2:0] exp_rgb [3];
  vid_t       exp_v;

  vga_sync_controller_if bus_a ();
  vga_sync_controller_if bus_b ();
  vga_sync_controller_if bus_c ();

  assign bus_a.rgbswitches = sw;
  assign bus_b.rgbswitches = sw;
  assign bus_c.rgbswitches = sw;

  vga_sync_controller u_a (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus_a)
  );

  vga_sync_controller #(
    .HD(16), .HF(4), .HR(6), .HB(6), .VD(10), .VF(2), .VR(2), .VB(3), .DIV(4)
  ) u_b (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus_b)
  );

  vga_sync_controller #(
    .HD(16), .HF(4), .HR(6), .HB(6), .VD(10), .VF(2), .VR(2), .VB(3), .DIV(2)
  ) u_c (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus_c)
  );

  // ---------------------------------------------------------------- clock/reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Edges since release, and the switch value present before each edge.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      k <= 0;
    end else begin
      sw_hist[16'(k + 1)] <= sw;
      k <= k + 1;
    end
  end

  // ---------------------------------------------------------------- model
  function automatic vid_t model(input int id, input int kk);
    int hd, hf, hr, hb, vd, vf, vr, vb, dv, ht, vt, pos, h, v;
    vid_t m;
    if (id == 0) begin
      hd = 640; hf = 16; hr = 96; hb = 48; vd = 480; vf = 10; vr = 2; vb = 33; dv = 4;
    end else begin
      hd = 16; hf = 4; hr = 6; hb = 6; vd = 10; vf = 2; vr = 2; vb = 3;
      dv = (id == 1) ? 4 : 2;
    end
    ht  = hd + hf + hr + hb;
    vt  = vd + vf + vr + vb;
    pos = (kk / dv) % (ht * vt);
    h   = pos % ht;
    v   = pos / ht;
    m.ptick      = ((kk % dv) == dv - 1);
    m.hsync      = !((h >= hd + hf) && (h < hd + hf + hr));
    m.vsync      = !((v >= vd + vf) && (v < vd + vf + vr));
    m.videoon    = (h < hd) && (v < vd);
    m.pixelx     = 10'(h);
    m.pixely     = 10'(v);
    m.framestart = (kk > 0) && ((kk % dv) == 0) && (pos == 0);
    m.rgbsel     = '0;
    return m;
  endfunction

  function automatic vid_t act_of(input int id);
    vid_t a;
    case (id)
      0: a = {bus_a.hsync, bus_a.vsync, bus_a.videoon, bus_a.pixelx, bus_a.pixely,
              bus_a.ptick, bus_a.framestart, bus_a.rgbsel};
      1: a = {bus_b.hsync, bus_b.vsync, bus_b.videoon, bus_b.pixelx, bus_b.pixely,
              bus_b.ptick, bus_b.framestart, bus_b.rgbsel};
      default: a = {bus_c.hsync, bus_c.vsync, bus_c.videoon, bus_c.pixelx, bus_c.pixely,
                    bus_c.ptick, bus_c.framestart, bus_c.rgbsel};
    endcase
    return a;
  endfunction

  // which: 0=hsync 1=vsync 2=framestart 3=ptick
  function automatic logic probe(input int id, input int which);
    vid_t a;
    a = act_of(id);
    case (which)
      0: return a.hsync;
      1: return a.vsync;
      2: return a.framestart;
      default: return a.ptick;
    endcase
  endfunction

  // ---------------------------------------------------------------- scoreboard
  task automatic check_frame(input int id, input vid_t act, input vid_t exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL model_dut%0d k=%0d: got hs=%b vs=%b vo=%b x=%0d y=%0d pt=%b fs=%b rgb=%b want hs=%b vs=%b vo=%b x=%0d y=%0d pt=%b fs=%b rgb=%b",
               id, k, act.hsync, act.vsync, act.videoon, act.pixelx, act.pixely, act.ptick,
               act.framestart, act.rgbsel, exp.hsync, exp.vsync, exp.videoon, exp.pixelx,
               exp.pixely, exp.ptick, exp.framestart, exp.rgbsel);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      for (int id = 0; id < 3; id++) begin
        exp_v = model(id, k);
        if (!resetn) exp_rgb[id] = '0;
        else if (exp_v.framestart) exp_rgb[id] = sw_hist[16'(k - 2)];
        exp_v.rgbsel = exp_rgb[id];
        check_frame(id, act_of(id), exp_v);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  // ---------------------------------------------------------------- drivers
  // Wait for a fresh transition of a probed signal to 'want'; returns cyc.
  task automatic wait_edge(input int id, input int which, input logic want,
                           input string name, output int at);
    logic prev, cur;
    prev = probe(id, which);
    at   = -1;
    for (int n = 0; n < 5000; n++) begin
      @(negedge clk);
      cur = probe(id, which);
      if (prev !== want && cur === want) begin
        at = cyc;
        break;
      end
      prev = cur;
    end
    if (at < 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: got timeout want transition", name);
    end
  endtask

  // Wait until instance 1 reaches (x,y); x < 0 means any column.
  task automatic wait_b_pos(input int x, input int y, input string name);
    int n;
    n = 0;
    while (!((x < 0 || int'(bus_b.pixelx) == x) && int'(bus_b.pixely) == y) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: got timeout want position %0d,%0d", name, x, y);
    end
  endtask

  // ---------------------------------------------------------------- stimulus
  int   n, t0, t1, t2, rel;
  logic changed;
  logic [2:0] old_rgb;

  initial begin
    n_checks = 0;
    n_errors = 0;
    cyc      = 0;
    sw       = '0;
    resetn   = 1'b1;
    chk_on   = 1'b0;
    #2 resetn = 1'b0;
    #1 chk_on = 1'b1;
    repeat (10) @(negedge clk);

    // Reset values
    chk("rst_pixelx",     bus_a.pixelx, 0);
    chk("rst_pixely",     bus_a.pixely, 0);
    chk("rst_hsync",      bus_a.hsync, 1);
    chk("rst_vsync",      bus_a.vsync, 1);
    chk("rst_videoon",    bus_a.videoon, 1);
    chk("rst_ptick",      bus_a.ptick, 0);
    chk("rst_framestart", bus_a.framestart, 0);
    chk("rst_rgbsel",     bus_a.rgbsel, 0);

    // Release: ptick consumed on the 4th edge, pixelx=1 afterwards
    resetn = 1'b1;
    n = 0;
    while (bus_a.ptick !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("first_ptick_edge", n + 1, 4);
    @(negedge clk);
    chk("pixelx_after_first_tick", bus_a.pixelx, 1);

    // Default line timing
    wait_edge(0, 0, 1'b0, "hs_fall_a", t0);
    chk("hs_fall_pixelx", bus_a.pixelx, 656);
    chk("hs_fall_videoon", bus_a.videoon, 0);
    wait_edge(0, 0, 1'b1, "hs_rise_a", t1);
    chk("hs_low_clks", t1 - t0, 384);
    wait_edge(0, 0, 1'b0, "hs_fall2_a", t2);
    chk("line_period_clks", t2 - t0, 3200);

    // Small-geometry frame timing, DIV=4
    wait_edge(1, 2, 1'b1, "fs1_b", t0);
    chk("fs_pixelx_b", bus_b.pixelx, 0);
    chk("fs_pixely_b", bus_b.pixely, 0);
    wait_edge(1, 2, 1'b1, "fs2_b", t1);
    chk("frame_period_b", t1 - t0, 2176);
    wait_edge(1, 1, 1'b0, "vs_fall_b", t0);
    chk("vs_fall_pixely_b", bus_b.pixely, 12);
    wait_edge(1, 1, 1'b1, "vs_rise_b", t1);
    chk("vs_low_clks_b", t1 - t0, 256);

    // DIV=2 variant
    wait_edge(2, 3, 1'b1, "pt1_c", t0);
    wait_edge(2, 3, 1'b1, "pt2_c", t1);
    chk("ptick_spacing_c", t1 - t0, 2);
    wait_edge(2, 0, 1'b0, "hs_fall_c", t0);
    wait_edge(2, 0, 1'b1, "hs_rise_c", t1);
    chk("hs_low_clks_c", t1 - t0, 12);
    wait_edge(2, 0, 1'b0, "hs_fall2_c", t2);
    chk("line_period_c", t2 - t0, 64);
    wait_edge(2, 2, 1'b1, "fs1_c", t0);
    wait_edge(2, 2, 1'b1, "fs2_c", t1);
    chk("frame_period_c", t1 - t0, 1088);

    // Colour latch: mid-frame change appears only at the wrap
    wait_b_pos(-1, 5, "colour_start");
    old_rgb = bus_b.rgbsel;
    chk("rgb_before_change", old_rgb, 0);
    sw = 3'b101;
    changed = 1'b0;
    n = 0;
    while (bus_b.framestart !== 1'b1 && n < 5000) begin
      if (bus_b.rgbsel !== old_rgb) changed = 1'b1;
      @(negedge clk);
      n++;
    end
    chk("rgb_hold_midframe", changed, 0);
    chk("rgb_latched_at_wrap", bus_b.rgbsel, 5);

    // A short glitch gone before the wrap is never latched
    wait_b_pos(-1, 5, "glitch_start");
    sw = 3'b010;
    repeat (3) @(negedge clk);
    sw = 3'b101;
    wait_edge(1, 2, 1'b1, "fs_after_glitch", t0);
    chk("rgb_glitch_ignored", bus_b.rgbsel, 5);

    // Asynchronous reset mid-frame
    wait_b_pos(8, 5, "midreset_pos");
    #2 resetn = 1'b0;
    #1;
    chk("midrst_pixelx_b", bus_b.pixelx, 0);
    chk("midrst_pixely_b", bus_b.pixely, 0);
    chk("midrst_hsync_b",  bus_b.hsync, 1);
    chk("midrst_vsync_b",  bus_b.vsync, 1);
    chk("midrst_rgbsel_b", bus_b.rgbsel, 0);
    chk("midrst_pixelx_a", bus_a.pixelx, 0);
    @(negedge clk);
    repeat (10) @(negedge clk);
    resetn = 1'b1;
    rel = cyc;
    wait_edge(2, 2, 1'b1, "fs_after_rst_c", t0);
    chk("first_frame_after_rst_c", t0 - rel, 1088);
    wait_edge(1, 2, 1'b1, "fs_after_rst_b", t1);
    chk("first_frame_after_rst_b", t1 - rel, 2176);
    wait_edge(0, 0, 1'b0, "hs_after_rst_a", t2);
    chk("first_hs_fall_after_rst_a", t2 - rel, 2624);

    @(negedge clk);
    chk_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
